// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with redirect and in-flight drop handling
//
// Purpose: issues word-aligned fetches to instruction memory, holds the returned
// word for decode under a valid/ready handshake and follows redirects. A redirect
// that arrives while a request is outstanding is remembered, and the stale response
// is drained before the new target is fetched.
//
// Ports:
//   clk_i, rst_ni                  clock (rising edge), asynchronous active-low reset
//   imem_req_o, imem_addr_o        memory request and word address
//   imem_rvalid_i, imem_rdata_i    memory response
//   instr_o, pc_o, pc_plus4_o      held instruction, its address, address + 4
//   instr_valid_o, instr_ready_i   decode handshake
//   pc_src_i, pc_target_i          redirect request and target
//   fetch_count_o                  number of instructions accepted by decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        pc_src_i,
  input  logic [31:0] pc_target_i,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;              // next address to fetch
  logic [31:0] drop_addr_q, drop_addr_d; // address of the request being drained
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;  // address of the held instruction
  logic [31:0] count_q, count_d;
  logic [31:0] target;

  assign target = {pc_target_i[31:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (pc_src_i) begin
          pc_d = target;
          if (!imem_rvalid_i) begin
            // Request stays in flight: keep presenting its address until it returns.
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (imem_rvalid_i) begin
          instr_d    = imem_rdata_i;
          instr_pc_d = pc_q;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (instr_ready_i) begin
          count_d = count_q + 32'd1;
          pc_d    = pc_src_i ? target : pc_q + 32'd4;
          state_d = FETCH;
        end else if (pc_src_i) begin
          pc_d    = target;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (pc_src_i) begin
          pc_d = target;
        end
        if (imem_rvalid_i) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      instr_q     <= NOP;
      instr_pc_q  <= RESET_PC;
      count_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      count_q     <= count_d;
    end
  end

  assign imem_req_o    = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr_o   = (state_q == DROP) ? drop_addr_q : pc_q;
  assign instr_valid_o = (state_q == VALID);
  assign instr_o       = instr_q;
  assign pc_o          = instr_pc_q;
  assign pc_plus4_o    = instr_pc_q + 32'd4;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk_i;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        pc_src_i;
  logic [31:0] pc_target_i;
  logic [31:0] fetch_count_o;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .pc_src_i      (pc_src_i),
    .pc_target_i   (pc_target_i),
    .fetch_count_o (fetch_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then drive the inputs for the coming rising edge.
  task automatic cyc(input logic rv, input logic [31:0] rd, input logic rdy,
                     input logic src, input logic [31:0] tgt);
    @(negedge clk_i);
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    instr_ready_i = rdy;
    pc_src_i      = src;
    pc_target_i   = tgt;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b0;
    pc_src_i      = 1'b0;
    pc_target_i   = 32'h0;

    // Reset state
    cyc(0, 0, 0, 0, 0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_count", fetch_count_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);

    // Release; pc_src in IDLE is ignored. First request one edge later at RESET_PC.
    cyc(0, 0, 0, 1, 32'h0000_0500);
    rst_ni = 1'b1;
    chk("idle_req", {31'd0, imem_req_o}, 32'd0);
    cyc(1, 32'h0050_0093, 1, 0, 0);
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'd0);

    // Zero-latency response -> VALID next cycle
    cyc(0, 0, 1, 0, 0);
    chk("v0_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("v0_instr", instr_o, 32'h0050_0093);
    chk("v0_pc", pc_o, 32'd0);
    chk("v0_pc4", pc_plus4_o, 32'd4);
    chk("v0_req", {31'd0, imem_req_o}, 32'd0);

    // Handshake -> fetch addr 4, count 1; memory latency 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("lat_req", {31'd0, imem_req_o}, 32'd1);
      chk("lat_addr", imem_addr_o, 32'd4);
      chk("lat_valid", {31'd0, instr_valid_o}, 32'd0);
    end
    chk("count1", fetch_count_o, 32'd1);
    cyc(1, 32'h00a0_0113, 0, 0, 0);
    chk("lat_req4", {31'd0, imem_req_o}, 32'd1);

    // VALID one cycle after rvalid, then held with ready=0 for 5 cycles
    for (int i = 0; i < 5; i++) begin
      cyc(0, 32'hffff_ffff, 0, 0, 0);
      chk("hold_valid", {31'd0, instr_valid_o}, 32'd1);
      chk("hold_instr", instr_o, 32'h00a0_0113);
      chk("hold_pc", pc_o, 32'd4);
      chk("hold_count", fetch_count_o, 32'd1);
    end
    // Handshake with redirect, unaligned target forced aligned
    cyc(0, 0, 1, 1, 32'h0000_0103);
    cyc(1, 32'h1111_1111, 1, 1, 32'h0000_0008);
    chk("redir_addr", imem_addr_o, 32'h0000_0100);
    chk("redir_count", fetch_count_o, 32'd2);
    chk("redir_req", {31'd0, imem_req_o}, 32'd1);

    // FETCH with redirect and rvalid together: data discarded, fetch at 8
    cyc(0, 0, 0, 1, 32'h0000_0040);
    chk("disc_addr", imem_addr_o, 32'h0000_0008);
    chk("disc_valid", {31'd0, instr_valid_o}, 32'd0);

    // Redirect while addr 8 outstanding -> DROP, address held at 8
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("drop_req", {31'd0, imem_req_o}, 32'd1);
      chk("drop_addr", imem_addr_o, 32'h0000_0008);
      chk("drop_valid", {31'd0, instr_valid_o}, 32'd0);
    end
    cyc(1, 32'hdead_beef, 1, 0, 0);
    chk("drop_last_addr", imem_addr_o, 32'h0000_0008);
    cyc(1, 32'h2222_2222, 1, 1, 32'hffff_ffff);
    chk("post_drop_addr", imem_addr_o, 32'h0000_0040);
    chk("post_drop_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("post_drop_count", fetch_count_o, 32'd2);

    // Redirect to top of address space, capture there
    cyc(1, 32'h0000_0013, 0, 0, 0);
    chk("top_addr", imem_addr_o, 32'hffff_fffc);
    cyc(0, 0, 0, 0, 0);
    chk("top_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("top_pc", pc_o, 32'hffff_fffc);
    chk("top_pc4", pc_plus4_o, 32'd0);

    // Preload counter to all-ones, then handshake: pc and count both wrap
    force dut.count_q = 32'hffff_ffff;
    #1;
    release dut.count_q;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 32'h0000_0033, 0, 0, 0);
    chk("wrap_addr", imem_addr_o, 32'd0);
    chk("wrap_count", fetch_count_o, 32'd0);

    // VALID, no ready, redirect: discard without counting
    cyc(0, 0, 0, 1, 32'h0000_0200);
    chk("v_redir_valid", {31'd0, instr_valid_o}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("v_redir_addr", imem_addr_o, 32'h0000_0200);
    chk("v_redir_count", fetch_count_o, 32'd0);
    chk("v_redir_vld", {31'd0, instr_valid_o}, 32'd0);

    // Reset during FETCH wait: immediate reset outputs, late rvalid ignored
    cyc(0, 0, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req_o}, 32'd0);
    chk("arst_instr", instr_o, 32'h0000_0013);
    chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("arst_pc", pc_o, 32'd0);
    cyc(1, 32'h4444_4444, 1, 0, 0);
    rst_ni = 1'b1;
    chk("arst_idle_req", {31'd0, imem_req_o}, 32'd0);
    cyc(0, 0, 1, 0, 0);
    chk("restart_req", {31'd0, imem_req_o}, 32'd1);
    chk("restart_addr", imem_addr_o, 32'd0);
    cyc(0, 0, 1, 0, 0);
    chk("restart_wait_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("restart_wait_req", {31'd0, imem_req_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
